// File: rtl/addsub_arbiter_if.sv
// Bundle for addsub_arbiter: the requester side (req/sub/a/b/ack) and the result side
// (o/o_tag/o_valid/o_ready).
// The optional ovf signal exists only when ADDSUB_ARBITER_OVF_EN is defined.
interface addsub_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int TAGW  = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       sub;
    logic [NREQ*WIDTH-1:0] a;
    logic [NREQ*WIDTH-1:0] b;
    logic [NREQ-1:0]       ack;
    logic [WIDTH:0]        o;
    logic [TAGW-1:0]       o_tag;
    logic                  o_valid;
    logic                  o_ready;
`ifdef ADDSUB_ARBITER_OVF_EN
    logic                  ovf;
`endif

    // Requesters and downstream consumer
    modport master (
        output req, sub, a, b, o_ready,
        input  ack, o, o_tag, o_valid
`ifdef ADDSUB_ARBITER_OVF_EN
        , input ovf
`endif
    );

    // The arbiter itself
    modport slave (
        input  req, sub, a, b, o_ready,
        output ack, o, o_tag, o_valid
`ifdef ADDSUB_ARBITER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter in front of a single shared add/sub unit with a one-entry
// result register. A requester is accepted (ack) whenever the result slot is
// free; its result appears on o one cycle later.
// Optional feature: define ADDSUB_ARBITER_OVF_EN to add the registered signed
// overflow flag ovf.
module addsub_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int TAGW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    addsub_arbiter_if.slave  bus
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q;
    logic              o_valid_q;
    logic [TAGW-1:0]   ptr_q;
    logic [WIDTH:0]    o_q;
    logic [TAGW-1:0]   o_tag_q;

    logic              grant_any_s;
    logic [TAGW-1:0]   grant_idx_s;
    logic [TAGW-1:0]   ptr_d;
    logic              slot_free_s;
    logic [NREQ-1:0]   ack_s;
    logic              ack_any_s;
    logic [WIDTH-1:0]  a_sel_s;
    logic [WIDTH-1:0]  b_sel_s;
    logic              sub_sel_s;
    logic [WIDTH-1:0]  b_x_s;
    logic [WIDTH:0]    o_d;

`ifdef ADDSUB_ARBITER_OVF_EN
    logic              ovf_q;
    logic              ovf_d;

    // Signed overflow: both addends share a sign that differs from the sum's sign
    function automatic logic ovf_f(input logic a_msb, input logic bx_msb, input logic s_msb);
        return (a_msb == bx_msb) && (s_msb != a_msb);
    endfunction
`endif

    // Round-robin search: first requester at or above ptr, wrapping to 0
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(ptr_q) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end else begin
                j = j;
            end
            if (!grant_any_s && bus.req[j]) begin
                grant_any_s = 1'b1;
                grant_idx_s = j[TAGW-1:0];
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Pointer advances to the requester just after the granted one
    always_comb begin
        ptr_d = '0;
        if (grant_idx_s == TAGW'(NREQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = grant_idx_s + TAGW'(1);
        end
    end

    // Acceptance strobe: one-hot, only when the slot frees up this cycle, never in reset
    always_comb begin
        slot_free_s = (state_q == EMPTY) || bus.o_ready;
        ack_s       = '0;
        if (rst) begin
            ack_s = '0;
        end else if (slot_free_s && grant_any_s) begin
            ack_s = NREQ'(1) << grant_idx_s;
        end else begin
            ack_s = '0;
        end
        ack_any_s = |ack_s;
    end

    // Shared unit: subtraction inverts B into the carry chain with carry-in = sub
    always_comb begin
        a_sel_s   = bus.a[grant_idx_s*WIDTH +: WIDTH];
        b_sel_s   = bus.b[grant_idx_s*WIDTH +: WIDTH];
        sub_sel_s = bus.sub[grant_idx_s];
        b_x_s     = b_sel_s ^ {WIDTH{sub_sel_s}};
        o_d       = {1'b0, a_sel_s} + {sub_sel_s, b_x_s} + {{WIDTH{1'b0}}, sub_sel_s};
`ifdef ADDSUB_ARBITER_OVF_EN
        ovf_d     = ovf_f(a_sel_s[WIDTH-1], b_x_s[WIDTH-1], o_d[WIDTH-1]);
`endif
    end

    // Output FSM and result register: load on ack, drain on o_ready, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            o_valid_q <= 1'b0;
            ptr_q     <= '0;
            o_q       <= '0;
            o_tag_q   <= '0;
`ifdef ADDSUB_ARBITER_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            if (ack_any_s) begin
                o_q     <= o_d;
                o_tag_q <= grant_idx_s;
                ptr_q   <= ptr_d;
`ifdef ADDSUB_ARBITER_OVF_EN
                ovf_q   <= ovf_d;
`endif
            end else begin
                ptr_q   <= ptr_q;
            end
            case (state_q)
                EMPTY: begin
                    if (ack_any_s) begin
                        state_q   <= FULL;
                        o_valid_q <= 1'b1;
                    end else begin
                        state_q   <= EMPTY;
                        o_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (ack_any_s) begin
                        state_q   <= FULL;
                        o_valid_q <= 1'b1;
                    end else if (bus.o_ready) begin
                        state_q   <= EMPTY;
                        o_valid_q <= 1'b0;
                    end else begin
                        state_q   <= FULL;
                        o_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= EMPTY;
                    o_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack     = ack_s;
    assign bus.o       = o_q;
    assign bus.o_tag   = o_tag_q;
    assign bus.o_valid = o_valid_q;
`ifdef ADDSUB_ARBITER_OVF_EN
    assign bus.ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed and random self-checking bench for addsub_arbiter (default parameters).
module tb_addsub_arbiter;
    localparam int W = 16;
    localparam int N = 4;
    localparam int T = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addsub_arbiter_if #(.WIDTH(W), .NREQ(N), .TAGW(T)) bus ();

    addsub_arbiter #(.WIDTH(W), .NREQ(N), .TAGW(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
        bus.a[i*W +: W] = av;
        bus.b[i*W +: W] = bv;
        bus.sub[i]      = s;
    endtask

    function automatic logic [W:0] ref_f(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
        return s ? ({1'b0, av} - {1'b0, bv}) : ({1'b0, av} + {1'b0, bv});
    endfunction

    task automatic run_single(input string tag, input int i, input logic [W-1:0] av,
                              input logic [W-1:0] bv, input logic s, input logic [W:0] exp_o);
        bus.o_ready = 1'b1;
        set_op(i, av, bv, s);
        bus.req = '0;
        bus.req[i] = 1'b1;
        #1;
        check_val({tag, "_ack"}, bus.ack, 32'(1) << i);
        tick();
        check_val({tag, "_o"}, bus.o, exp_o);
        check_val({tag, "_tag"}, bus.o_tag, i);
        check_val({tag, "_valid"}, bus.o_valid, 1);
        bus.req = '0;
    endtask

    // Safety net so the run always ends
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic            m_valid;
        logic [T-1:0]    m_tag;
        logic [W:0]      m_o;
        int              m_ptr;
        int              g;
        logic [N-1:0]    exp_ack;

        rst = 1'b1;
        bus.req = '0; bus.sub = '0; bus.a = '0; bus.b = '0; bus.o_ready = 1'b0;
        tick();

        // Reset state, and ack held low while rst is high even with requests pending
        bus.req = '1; bus.o_ready = 1'b1;
        tick(); tick();
        check_val("rst_ack", bus.ack, 0);
        check_val("rst_valid", bus.o_valid, 0);
        check_val("rst_o", bus.o, 0);
        check_val("rst_tag", bus.o_tag, 0);
        bus.req = '0;
        rst = 1'b0;

        // Single requester 2: 5 - 7 wraps to 0x1FFFE
        run_single("sub57", 2, 16'h0005, 16'h0007, 1'b1, 17'h1FFFE);
        tick();
        check_val("drain_valid", bus.o_valid, 0);
        tick();
        check_val("empty_ready_valid", bus.o_valid, 0);

        // Round-robin from reset with all four requesting
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, W'(i * 16'h1111), W'(i + 3), 1'(i % 2));
        bus.req = '1; bus.o_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_val("rr_ack", bus.ack, 32'(1) << (c % N));
            tick();
            check_val("rr_tag", bus.o_tag, c % N);
            check_val("rr_valid", bus.o_valid, 1);
            check_val("rr_o", bus.o, ref_f(W'((c % N) * 16'h1111), W'((c % N) + 3), 1'((c % N) % 2)));
        end

        // Back-pressure: result of requester 0 held for 5 cycles, then requester 1 accepted
        bus.o_ready = 1'b0;
        bus.req = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_val("stall_ack", bus.ack, 0);
            tick();
            check_val("stall_tag", bus.o_tag, 0);
            check_val("stall_o", bus.o, ref_f(16'h0000, 16'h0003, 1'b0));
            check_val("stall_valid", bus.o_valid, 1);
        end
        bus.o_ready = 1'b1;
        #1;
        check_val("unstall_ack", bus.ack, 32'h2);
        tick();
        check_val("unstall_tag", bus.o_tag, 1);
        check_val("unstall_o", bus.o, ref_f(16'h1111, 16'h0004, 1'b1));
        bus.req = '0;

        // Carry out and signed-overflow boundaries
        run_single("carry", 3, 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
        run_single("pos_ovf", 1, 16'h7FFF, 16'h0001, 1'b0, 17'h08000);
`ifdef ADDSUB_ARBITER_OVF_EN
        check_val("pos_ovf_flag", bus.ovf, 1);
`endif
        run_single("neg_ovf", 0, 16'h8000, 16'h0001, 1'b1, 17'h07FFF);
`ifdef ADDSUB_ARBITER_OVF_EN
        check_val("neg_ovf_flag", bus.ovf, 1);
`endif
        run_single("no_ovf", 2, 16'h0003, 16'h0004, 1'b0, 17'h00007);
`ifdef ADDSUB_ARBITER_OVF_EN
        check_val("no_ovf_flag", bus.ovf, 0);
`endif

        // Reset while FULL with all requesting: result discarded, grant restarts at 0
        bus.req = '1; bus.o_ready = 1'b1; rst = 1'b1;
        #1;
        check_val("rstmid_ack", bus.ack, 0);
        tick();
        check_val("rstmid_valid", bus.o_valid, 0);
        check_val("rstmid_o", bus.o, 0);
        rst = 1'b0;
        #1;
        check_val("rstmid_first_ack", bus.ack, 32'h1);
        tick();
        check_val("rstmid_first_tag", bus.o_tag, 0);
        check_val("rstmid_first_valid", bus.o_valid, 1);
        bus.req = '0;

        // Random traffic against an independent arbiter/arithmetic model
        rst = 1'b1; tick(); rst = 1'b0;
        m_valid = 1'b0; m_tag = '0; m_o = '0; m_ptr = 0; g = -1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            check_val("rnd_valid", bus.o_valid, m_valid);
            if (m_valid) begin
                check_val("rnd_o", bus.o, m_o);
                check_val("rnd_tag", bus.o_tag, m_tag);
            end
            if (g >= 0) bus.req[g] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    if ($urandom_range(0, 7) == 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    set_op(i, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
                    bus.req[i] = 1'b1;
                end
            end
            bus.o_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            exp_ack = '0;
            if (!m_valid || bus.o_ready) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (g < 0 && bus.req[j]) g = j;
                end
            end
            if (g >= 0) exp_ack[g] = 1'b1;
            check_val("rnd_ack", bus.ack, exp_ack);
            if (g >= 0) begin
                m_o     = ref_f(bus.a[g*W +: W], bus.b[g*W +: W], bus.sub[g]);
                m_tag   = T'(g);
                m_valid = 1'b1;
                m_ptr   = (g + 1) % N;
            end else if (bus.o_ready) begin
                m_valid = 1'b0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..16).
REQ-003 SHALL have parameter TAGW, default 2, tag width; TAGW >= clog2(NREQ).
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  NREQ  per-requester operation request.
REQ-007 SHALL have port sub  input  NREQ  per-requester op select: 1 = a-b, 0 = a+b.
REQ-008 SHALL have port a  input  NREQ*WIDTH  flattened operand A, requester i at [i*WIDTH +: WIDTH].
REQ-009 SHALL have port b  input  NREQ*WIDTH  flattened operand B, same packing.
REQ-010 SHALL have port ack  output  NREQ  one-hot combinational acceptance strobe.
REQ-011 SHALL have port o  output  WIDTH+1  registered result.
REQ-012 SHALL have port o_tag  output  TAGW  index of requester owning o.
REQ-013 SHALL have port o_valid  output  1  result register holds an undelivered result.
REQ-014 SHALL have port o_ready  input  1  downstream accepts o this cycle.

Function
REQ-015 SHALL compute o = ({1'b0,a_i} + {1'b0,b_i}) when sub_i=0, ({1'b0,a_i} - {1'b0,b_i}) when sub_i=1, modulo 2^(WIDTH+1).
REQ-016 SHALL implement the shared unit as one XOR-into-carry-chain add/sub, the sole arithmetic resource.
REQ-017 SHALL have output state machine states EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-018 SHALL treat the slot as free when state is EMPTY, or FULL with o_ready=1.
REQ-019 SHALL assert at most one ack bit, only when slot free and at least one req bit high.
REQ-020 SHALL pick the granted index round-robin: first req bit set searching upward from pointer ptr, wrapping NREQ-1 to 0.
REQ-021 SHALL, after an ack to i, set ptr = (i+1) mod NREQ next cycle; ptr unchanged otherwise.
REQ-022 SHALL, on ack to i, load o, o_tag=i and enter FULL next cycle (latency 1 cycle).
REQ-023 SHALL, on FULL with o_ready=1 and no ack, go EMPTY next cycle.
REQ-024 SHALL, on FULL with o_ready=1 and ack in the same cycle, replace the result and stay FULL (back-to-back throughput 1/cycle).
REQ-025 SHALL hold o, o_tag stable while FULL and o_ready=0; ack stays 0.
REQ-026 SHALL ignore o_ready when EMPTY.
REQ-027 SHALL require requesters to hold req, sub, a, b stable until ack; req may drop without ack.
REQ-028 SHALL guarantee every continuously asserted req is acked within NREQ grants.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, set state EMPTY, o_valid=0, ptr=0, o=0, o_tag=0.
REQ-030 SHALL force ack=0 while rst=1.
REQ-031 SHALL discard any undelivered result on reset mid-operation; no further output for it.

Configuration
REQ-032 SHALL recognise macro ADDSUB_ARBITER_OVF_EN.
REQ-033 SHALL, with ADDSUB_ARBITER_OVF_EN defined, add output port ovf (1 bit), registered alongside o: signed overflow of the WIDTH-bit two's-complement a_i ± b_i, reset 0.
REQ-034 SHALL, without ADDSUB_ARBITER_OVF_EN, have no ovf port and no overflow logic; all other behaviour identical.

Verification
REQ-035 SHALL check: WIDTH=16, only req[2], a=0x0005, b=0x0007, sub=1, o_ready=1 -> ack=0100 same cycle; next cycle o=0x1FFFE, o_tag=2, o_valid=1.
REQ-036 SHALL check: req=1111 held, o_ready=1 from reset -> ack order 0,1,2,3,0, one per cycle, o_valid continuously 1 from second cycle.
REQ-037 SHALL check: FULL with o_ready=0 for 5 cycles, req[1] high -> ack=0 and o, o_tag unchanged for 5 cycles; ack[1] in cycle o_ready rises.
REQ-038 SHALL check: a=0xFFFF, b=0x0001, sub=0 -> o=0x10000; with OVF_EN, a=0x7FFF, b=0x0001, sub=0 -> ovf=1, a=0x8000, b=0x0001, sub=1 -> ovf=1.
REQ-039 SHALL check: rst asserted one cycle while FULL and req=1111 -> ack=0 that cycle, next cycle o_valid=0, first grant after release to requester 0.
REQ-040 SHALL compare every delivered result against a reference model of REQ-015 over 10000 random cycles with random req and o_ready.
